sda_tristate_pad: RTL and testbench

Bidirectional pad cell for the I2C master's SDA line. It drives the shared pin from the master's data and output-enable signals. It returns a synchronized, glitch-filtered copy of the pin to the master, and flags line edges and drive contention. It sits between the `i2c_master` state machine and the top-level `inout` SDA pin.

---
 rtl/sda_tristate_pad.sv | 100 ++++++++++
 tb/tb_sda_tristate_pad.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sda_tristate_pad.sv
// SDA pad cell: open-drain or push-pull drive of the shared pin, plus a synchronized,
// glitch-filtered pin level with edge pulses and a drive-contention flag.
module sda_tristate_pad #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter bit OPEN_DRAIN  = 1'b1
) (
   input  logic clk,
   input  logic reset,
   inout  wire  pin,
   input  logic oe,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic conflict
);

   localparam int CNT_W      = $clog2(FILTER_LEN) + 1;
   localparam int SETTLE_MAX = SYNC_STAGES + FILTER_LEN;
   localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);

   localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(FILTER_LEN - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_SAT = SETTLE_W'(SETTLE_MAX);

   logic                   drive_en;
   logic                   drive_val;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic [CNT_W-1:0]       cnt;
   logic                   flip;
   logic                   din_q;
   logic [SETTLE_W-1:0]    settle;
   logic                   steady;

   // The pad lets go of the line whenever reset is held, whatever the master requests.
   always_comb begin
      if (OPEN_DRAIN) begin
         drive_en  = reset & oe & ~din;
         drive_val = 1'b0;
      end else begin
         drive_en  = reset & oe;
         drive_val = din;
      end
   end

   assign pin = drive_en ? drive_val : 1'bz;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];
   assign flip = (sync != dout) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         dout <= 1'b1;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= flip & sync;
         fall <= flip & ~sync;
         if (sync == dout) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            dout <= sync;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // din_q resets high (idle bus level) so a master that asserts oe with din=1 straight
   // out of reset counts as settled from the first edge.
   assign steady = oe && (din == din_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         din_q    <= 1'b1;
         settle   <= '0;
         conflict <= 1'b0;
      end else begin
         din_q <= din;
         if (!steady) begin
            settle <= '0;
         end else if (settle != SETTLE_SAT) begin
            settle <= settle + SETTLE_W'(1);
         end
         conflict <= steady && (settle == SETTLE_SAT) && (dout != din);
      end
   end

endmodule

// File: tb/tb_sda_tristate_pad.sv
// Bench for sda_tristate_pad: combinational drive table, hand-written timing sequences
// and randomized traffic checked against a window-based model of the pad.
module tb_sda_tristate_pad;

   localparam int SYNC = 2;
   localparam int FILT = 3;
   localparam int SMAX = SYNC + FILT;
   localparam int LAT  = SYNC + FILT - 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic oe_od = 1'b0, din_od = 1'b1, ext_low = 1'b0;
   logic oe_pp = 1'b0, din_pp = 1'b1;

   wire pin_od;
   wire pin_pp;
   pullup (pin_od);
   pullup (pin_pp);
   assign pin_od = ext_low ? 1'b0 : 1'bz;

   logic dout_od, rise_od, fall_od, conflict_od;
   logic dout_pp, rise_pp, fall_pp, conflict_pp;

   always #5 clk = ~clk;

   sda_tristate_pad #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .OPEN_DRAIN(1'b1)) u_od (
      .clk(clk), .reset(reset), .pin(pin_od), .oe(oe_od), .din(din_od),
      .dout(dout_od), .rise(rise_od), .fall(fall_od), .conflict(conflict_od)
   );

   sda_tristate_pad #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .OPEN_DRAIN(1'b0)) u_pp (
      .clk(clk), .reset(reset), .pin(pin_pp), .oe(oe_pp), .din(din_pp),
      .dout(dout_pp), .rise(rise_pp), .fall(fall_pp), .conflict(conflict_pp)
   );

   typedef struct {
      logic oe;
      logic din;
      logic ext;
      logic exp_od;
      logic exp_pp;
   } vec_t;

   vec_t vecs [8];

   int   checks   = 0;
   int   failures = 0;
   int   edge_n   = 0;
   logic oe_h  [0:4095];
   logic din_h [0:4095];
   logic pin_h [0:4095];
   logic pp_h  [0:4095];
   logic m_dout = 1'b1;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d actual=%b required=%b", name, edge_n, act, exp);
      end
   endtask

   function automatic logic od_pin_exp();
      return !(ext_low || (oe_od && !din_od));
   endfunction

   function automatic logic pp_pin_exp();
      return oe_pp ? din_pp : 1'b1;
   endfunction

   // sync value the filter sees just before edge n: the pin as sampled SYNC edges earlier
   function automatic logic sync_at(input int n);
      return (n - SYNC >= 1) ? pin_h[n-SYNC] : 1'b1;
   endfunction

   function automatic logic din_at(input int n);
      return (n >= 1) ? din_h[n] : 1'b1;
   endfunction

   function automatic logic pp_at(input int n);
      return (n >= 1) ? pp_h[n] : 1'b1;
   endfunction

   task automatic tick();
      logic upd, stable, dout_before, m_rise, m_fall, m_conflict, pp_now, pp_prev;
      @(posedge clk);
      #1;
      edge_n++;
      if (edge_n >= 4095) begin
         $display("FAIL edge_budget edge=%0d actual=overflow required=below_4095", edge_n);
         failures++;
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $fatal(1, "edge budget exceeded");
      end
      oe_h[edge_n]  = oe_od;
      din_h[edge_n] = din_od;
      pin_h[edge_n] = od_pin_exp();
      pp_h[edge_n]  = pp_pin_exp();

      // dout flips once FILT consecutive sync samples all disagree with it
      upd = 1'b1;
      for (int k = 0; k < FILT; k++) begin
         if (edge_n - k < 1 || sync_at(edge_n - k) == m_dout) upd = 1'b0;
      end
      dout_before = m_dout;
      m_rise = upd && !m_dout;
      m_fall = upd && m_dout;
      if (upd) m_dout = !m_dout;

      // conflict needs SMAX+1 edges of oe=1 with din unchanged since the edge before them
      stable = (edge_n - SMAX >= 1);
      if (stable) begin
         for (int k = 0; k <= SMAX; k++) begin
            if (!oe_h[edge_n-k] || din_h[edge_n-k] != din_at(edge_n - SMAX - 1)) stable = 1'b0;
         end
      end
      m_conflict = stable && (dout_before != din_od);

      chk("od_dout", dout_od, m_dout);
      chk("od_rise", rise_od, m_rise);
      chk("od_fall", fall_od, m_fall);
      chk("od_conflict", conflict_od, m_conflict);
      chk("od_pin", pin_od, od_pin_exp());

      pp_now  = pp_at(edge_n - LAT);
      pp_prev = pp_at(edge_n - LAT - 1);
      chk("pp_dout", dout_pp, pp_now);
      chk("pp_rise", rise_pp, pp_now & ~pp_prev);
      chk("pp_fall", fall_pp, ~pp_now & pp_prev);
      chk("pp_conflict", conflict_pp, 1'b0);
      chk("pp_pin", pin_pp, pp_pin_exp());
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_dout", dout_od, 1'b1);
      chk("rst_flags", rise_od | fall_od | conflict_od, 1'b0);
      chk("rst_pp_dout", dout_pp, 1'b1);
      chk("rst_pp_pin", pin_pp, 1'b1);
      chk("rst_od_pin", pin_od, !ext_low);
      edge_n = 0;
      m_dout = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_hold_dout", dout_od, 1'b1);
      chk("rst_hold_pp_pin", pin_pp, 1'b1);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t actual=running required=finished", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

      #3;
      do_reset();

      // combinational drive table
      for (int i = 0; i < 8; i++) begin
         oe_od   = vecs[i].oe;
         din_od  = vecs[i].din;
         ext_low = vecs[i].ext;
         oe_pp   = vecs[i].oe;
         din_pp  = vecs[i].din;
         #1;
         chk("tbl_od_pin", pin_od, vecs[i].exp_od);
         chk("tbl_pp_pin", pin_pp, vecs[i].exp_pp);
      end

      // idle after reset: line released, nothing moves
      oe_od = 1'b0; din_od = 1'b1; ext_low = 1'b0; oe_pp = 1'b0; din_pp = 1'b1;
      do_reset();
      for (int e = 1; e <= 8; e++) begin
         tick();
         chk("s1_dout", dout_od, 1'b1);
         chk("s1_flags", rise_od | fall_od | conflict_od, 1'b0);
      end

      // master pulls low from edge 0
      do_reset();
      oe_od = 1'b1; din_od = 1'b0;
      #1;
      chk("s2_pin_now", pin_od, 1'b0);
      for (int e = 1; e <= 12; e++) begin
         tick();
         chk("s2_dout", dout_od, e < 5);
         chk("s2_fall", fall_od, e == 5);
         chk("s2_conflict", conflict_od, 1'b0);
      end

      // external low pulses: 2 cycles filtered out, 3 cycles pass
      oe_od = 1'b0; din_od = 1'b1;
      do_reset();
      ext_low = 1'b1;
      tick();
      tick();
      ext_low = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         chk("s3_short_dout", dout_od, 1'b1);
         chk("s3_short_fall", fall_od, 1'b0);
      end
      for (int i = 1; i <= 14; i++) begin
         ext_low = (i <= 3);
         tick();
         chk("s3_fall", fall_od, i == 5);
         chk("s3_rise", rise_od, i == 8);
         chk("s3_dout", dout_od, !(i >= 5 && i < 8));
      end

      // arbitration loss: master releases (din=1) while another device holds low
      ext_low = 1'b1;
      do_reset();
      oe_od = 1'b1; din_od = 1'b1;
      #1;
      chk("s4_pin", pin_od, 1'b0);
      for (int e = 1; e <= 10; e++) begin
         tick();
         chk("s4_dout", dout_od, e < 5);
         chk("s4_conflict", conflict_od, e >= 6);
      end
      oe_od = 1'b0;
      tick();
      chk("s4_conflict_clear", conflict_od, 1'b0);
      tick();

      // push-pull data pattern 1,0,1 with 8-cycle holds
      ext_low = 1'b0; oe_od = 1'b0; din_od = 1'b1;
      do_reset();
      oe_pp = 1'b1;
      for (int seg = 0; seg < 3; seg++) begin
         din_pp = (seg != 1);
         #1;
         chk("s5_pin", pin_pp, seg != 1);
         for (int h = 1; h <= 8; h++) begin
            tick();
            if (seg == 0) chk("s5_lag0", dout_pp, 1'b1);
            if (seg == 1) chk("s5_lag1", dout_pp, h < 5);
            if (seg == 2) chk("s5_lag2", dout_pp, h >= 5);
            chk("s5_conflict", conflict_pp, 1'b0);
         end
      end

      // reset in the middle of a filter run, pin still low afterwards
      oe_pp = 1'b1; din_pp = 1'b0; oe_od = 1'b0; din_od = 1'b1; ext_low = 1'b1;
      do_reset();
      for (int e = 1; e <= 4; e++) begin
         tick();
         chk("s6_pre_dout", dout_od, 1'b1);
      end
      do_reset();
      for (int e = 1; e <= 8; e++) begin
         tick();
         chk("s6_fall", fall_od, e == 5);
         chk("s6_dout", dout_od, e < 5);
      end

      // randomized traffic on the open-drain pad
      ext_low = 1'b0; oe_od = 1'b0; din_od = 1'b1; oe_pp = 1'b0; din_pp = 1'b1;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 9) == 0) oe_od = ~oe_od;
         if ($urandom_range(0, 9) == 0) din_od = ~din_od;
         if ($urandom_range(0, 5) == 0) ext_low = ~ext_low;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
